// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types and constants for the writeback/commit stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam logic [4:0]  WB_X0 = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        endsim;
    logic [63:0] value;
    logic        redirect;
    logic [63:0] target;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_commit_queue.sv
// ============================================================================
// Module : wb_commit_queue
// Brief  : Tagged in-order entry array with alloc/complete write ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = wb_pkg::DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc0_i,
  input  logic             alloc1_i,
  input  logic [4:0]       alloc0_rd_i,
  input  logic             alloc0_rd_wen_i,
  input  logic             alloc0_endsim_i,
  input  logic [4:0]       alloc1_rd_i,
  input  logic             alloc1_rd_wen_i,
  input  logic             alloc1_endsim_i,
  input  logic             cmp0_valid_i,
  input  logic [TAG_W-1:0] cmp0_tag_i,
  input  logic [63:0]      cmp0_value_i,
  input  logic             cmp0_redirect_i,
  input  logic [63:0]      cmp0_target_i,
  input  logic             cmp1_valid_i,
  input  logic [TAG_W-1:0] cmp1_tag_i,
  input  logic [63:0]      cmp1_value_i,
  input  logic             cmp1_redirect_i,
  input  logic [63:0]      cmp1_target_i,
  input  logic [1:0]       commit_n_i,
  input  logic             flush_i,
  output wb_entry_t        entries_o [DEPTH],
  output logic [TAG_W-1:0] head_o,
  output logic [TAG_W-1:0] tail_o,
  output logic [TAG_W:0]   count_o
);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0] rd_wen_q, endsim_q, redirect_q;
  logic [4:0]       rd_q     [DEPTH];
  logic [63:0]      value_q  [DEPTH];
  logic [63:0]      target_q [DEPTH];

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [TAG_W:0]   count_q, count_d;
  logic [1:0]       alloc_n;
  logic             cmp0_we, cmp1_we, pair_alloc;

  assign head_p1    = head_q + TAG_W'(1);
  assign tail_p1    = tail_q + TAG_W'(1);
  assign pair_alloc = alloc0_i & alloc1_i;
  assign alloc_n    = {1'b0, alloc0_i} + {1'b0, pair_alloc};
  assign cmp0_we    = cmp0_valid_i & valid_q[cmp0_tag_i] & ~flush_i;
  assign cmp1_we    = cmp1_valid_i & valid_q[cmp1_tag_i] & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      // The redirecting head retires; everything younger is squashed.
      valid_d = '0;
      done_d  = '0;
      head_d  = head_p1;
      tail_d  = head_p1;
      count_d = '0;
    end else begin
      if (cmp0_we) done_d[cmp0_tag_i] = 1'b1;
      if (cmp1_we) done_d[cmp1_tag_i] = 1'b1;
      if (commit_n_i != 2'd0) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end
      if (commit_n_i == 2'd2) begin
        valid_d[head_p1] = 1'b0;
        done_d[head_p1]  = 1'b0;
      end
      if (alloc0_i) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
      end
      if (pair_alloc) begin
        valid_d[tail_p1] = 1'b1;
        done_d[tail_p1]  = 1'b0;
      end
      head_d  = head_q + TAG_W'(commit_n_i);
      tail_d  = tail_q + TAG_W'(alloc_n);
      count_d = count_q + (TAG_W+1)'(alloc_n) - (TAG_W+1)'(commit_n_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (alloc0_i) begin
        rd_q[tail_q]     <= alloc0_rd_i;
        rd_wen_q[tail_q] <= alloc0_rd_wen_i;
        endsim_q[tail_q] <= alloc0_endsim_i;
      end
      if (pair_alloc) begin
        rd_q[tail_p1]     <= alloc1_rd_i;
        rd_wen_q[tail_p1] <= alloc1_rd_wen_i;
        endsim_q[tail_p1] <= alloc1_endsim_i;
      end
      if (cmp0_we) begin
        value_q[cmp0_tag_i]    <= cmp0_value_i;
        redirect_q[cmp0_tag_i] <= cmp0_redirect_i;
        target_q[cmp0_tag_i]   <= cmp0_target_i;
      end
      if (cmp1_we) begin
        value_q[cmp1_tag_i]    <= cmp1_value_i;
        redirect_q[cmp1_tag_i] <= cmp1_redirect_i;
        target_q[cmp1_tag_i]   <= cmp1_target_i;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign entries_o[g] = '{valid:    valid_q[g],
                            done:     done_q[g],
                            rd:       rd_q[g],
                            rd_wen:   rd_wen_q[g],
                            endsim:   endsim_q[g],
                            value:    value_q[g],
                            redirect: redirect_q[g],
                            target:   target_q[g]};
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/wb_commit.sv
// ============================================================================
// Module : wb_commit
// Brief  : Dual-issue in-order commit: selects retiring entries, drives the
//          two regfile write ports and the redirect flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_commit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = wb_pkg::DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst0_alloc_valid_i,
  input  logic [4:0]       inst0_alloc_rd_i,
  input  logic             inst0_alloc_rd_wen_i,
  input  logic             inst0_alloc_endsim_i,
  input  logic             inst1_alloc_valid_i,
  input  logic [4:0]       inst1_alloc_rd_i,
  input  logic             inst1_alloc_rd_wen_i,
  input  logic             inst1_alloc_endsim_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] inst0_tag_o,
  output logic [TAG_W-1:0] inst1_tag_o,
  input  logic             cmp0_valid_i,
  input  logic [TAG_W-1:0] cmp0_tag_i,
  input  logic [63:0]      cmp0_value_i,
  input  logic             cmp0_redirect_i,
  input  logic [63:0]      cmp0_target_i,
  input  logic             cmp1_valid_i,
  input  logic [TAG_W-1:0] cmp1_tag_i,
  input  logic [63:0]      cmp1_value_i,
  input  logic             cmp1_redirect_i,
  input  logic [63:0]      cmp1_target_i,
  output logic             inst0_wb_valid_o,
  output logic [4:0]       inst0_wb_rd_o,
  output logic [63:0]      inst0_wb_value_o,
  output logic             inst1_wb_valid_o,
  output logic [4:0]       inst1_wb_rd_o,
  output logic [63:0]      inst1_wb_value_o,
  output logic             flush_o,
  output logic [63:0]      flush_pc_o,
  output logic             endsim_o
);

  wb_entry_t        entries [DEPTH];
  wb_entry_t        e0, e1;
  logic [TAG_W-1:0] head, tail, head_p1;
  logic [TAG_W:0]   count;
  logic             alloc0, alloc1, slot0, slot1, flush;
  logic [1:0]       commit_n;

  logic             wb0_valid_q, wb1_valid_q, flush_q, endsim_q;
  logic [4:0]       wb0_rd_q, wb1_rd_q;
  logic [63:0]      wb0_value_q, wb1_value_q, flush_pc_q;

  assign alloc_ready_o = (count <= (TAG_W+1)'(DEPTH - 2));
  assign alloc0        = alloc_ready_o & inst0_alloc_valid_i;
  assign alloc1        = alloc0 & inst1_alloc_valid_i;
  assign inst0_tag_o   = tail;
  assign inst1_tag_o   = tail + TAG_W'(1);

  assign head_p1 = head + TAG_W'(1);
  assign e0      = entries[head];
  assign e1      = entries[head_p1];

  // A redirect/endsim on the second candidate waits until it becomes head,
  // so flush and endsim are only ever raised from slot0.
  assign slot0    = ~endsim_q & e0.valid & e0.done;
  assign slot1    = slot0 & ~e0.redirect & ~e0.endsim & e1.valid & e1.done
                  & ~e1.redirect & ~e1.endsim;
  assign flush    = slot0 & e0.redirect;
  assign commit_n = {slot1, slot0 & ~slot1};

  wb_commit_queue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_queue (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc0_i        (alloc0),
    .alloc1_i        (alloc1),
    .alloc0_rd_i     (inst0_alloc_rd_i),
    .alloc0_rd_wen_i (inst0_alloc_rd_wen_i),
    .alloc0_endsim_i (inst0_alloc_endsim_i),
    .alloc1_rd_i     (inst1_alloc_rd_i),
    .alloc1_rd_wen_i (inst1_alloc_rd_wen_i),
    .alloc1_endsim_i (inst1_alloc_endsim_i),
    .cmp0_valid_i    (cmp0_valid_i),
    .cmp0_tag_i      (cmp0_tag_i),
    .cmp0_value_i    (cmp0_value_i),
    .cmp0_redirect_i (cmp0_redirect_i),
    .cmp0_target_i   (cmp0_target_i),
    .cmp1_valid_i    (cmp1_valid_i),
    .cmp1_tag_i      (cmp1_tag_i),
    .cmp1_value_i    (cmp1_value_i),
    .cmp1_redirect_i (cmp1_redirect_i),
    .cmp1_target_i   (cmp1_target_i),
    .commit_n_i      (commit_n),
    .flush_i         (flush),
    .entries_o       (entries),
    .head_o          (head),
    .tail_o          (tail),
    .count_o         (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb0_valid_q <= 1'b0;
      wb0_rd_q    <= '0;
      wb0_value_q <= '0;
      wb1_valid_q <= 1'b0;
      wb1_rd_q    <= '0;
      wb1_value_q <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      endsim_q    <= 1'b0;
    end else begin
      wb0_valid_q <= slot0 & e0.rd_wen & (e0.rd != WB_X0);
      wb1_valid_q <= slot1 & e1.rd_wen & (e1.rd != WB_X0);
      if (slot0) begin
        wb0_rd_q    <= e0.rd;
        wb0_value_q <= e0.value;
      end
      if (slot1) begin
        wb1_rd_q    <= e1.rd;
        wb1_value_q <= e1.value;
      end
      flush_q <= flush;
      if (flush) flush_pc_q <= e0.target;
      if (slot0 & e0.endsim) endsim_q <= 1'b1;
    end
  end

  assign inst0_wb_valid_o = wb0_valid_q;
  assign inst0_wb_rd_o    = wb0_rd_q;
  assign inst0_wb_value_o = wb0_value_q;
  assign inst1_wb_valid_o = wb1_valid_q;
  assign inst1_wb_rd_o    = wb1_rd_q;
  assign inst1_wb_value_o = wb1_value_q;
  assign flush_o          = flush_q;
  assign flush_pc_o       = flush_pc_q;
  assign endsim_o         = endsim_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_commit.sv
// ============================================================================
// Module : tb_wb_commit
// Brief  : Directed self-checking bench for wb_commit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_commit;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             inst0_alloc_valid_i, inst1_alloc_valid_i;
  logic [4:0]       inst0_alloc_rd_i, inst1_alloc_rd_i;
  logic             inst0_alloc_rd_wen_i, inst1_alloc_rd_wen_i;
  logic             inst0_alloc_endsim_i, inst1_alloc_endsim_i;
  logic             alloc_ready_o;
  logic [TAG_W-1:0] inst0_tag_o, inst1_tag_o;
  logic             cmp0_valid_i, cmp1_valid_i;
  logic [TAG_W-1:0] cmp0_tag_i, cmp1_tag_i;
  logic [63:0]      cmp0_value_i, cmp1_value_i, cmp0_target_i, cmp1_target_i;
  logic             cmp0_redirect_i, cmp1_redirect_i;
  logic             inst0_wb_valid_o, inst1_wb_valid_o;
  logic [4:0]       inst0_wb_rd_o, inst1_wb_rd_o;
  logic [63:0]      inst0_wb_value_o, inst1_wb_value_o;
  logic             flush_o, endsim_o;
  logic [63:0]      flush_pc_o;

  int tests = 0;
  int fails = 0;

  wb_commit #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .inst0_alloc_valid_i  (inst0_alloc_valid_i),
    .inst0_alloc_rd_i     (inst0_alloc_rd_i),
    .inst0_alloc_rd_wen_i (inst0_alloc_rd_wen_i),
    .inst0_alloc_endsim_i (inst0_alloc_endsim_i),
    .inst1_alloc_valid_i  (inst1_alloc_valid_i),
    .inst1_alloc_rd_i     (inst1_alloc_rd_i),
    .inst1_alloc_rd_wen_i (inst1_alloc_rd_wen_i),
    .inst1_alloc_endsim_i (inst1_alloc_endsim_i),
    .alloc_ready_o        (alloc_ready_o),
    .inst0_tag_o          (inst0_tag_o),
    .inst1_tag_o          (inst1_tag_o),
    .cmp0_valid_i         (cmp0_valid_i),
    .cmp0_tag_i           (cmp0_tag_i),
    .cmp0_value_i         (cmp0_value_i),
    .cmp0_redirect_i      (cmp0_redirect_i),
    .cmp0_target_i        (cmp0_target_i),
    .cmp1_valid_i         (cmp1_valid_i),
    .cmp1_tag_i           (cmp1_tag_i),
    .cmp1_value_i         (cmp1_value_i),
    .cmp1_redirect_i      (cmp1_redirect_i),
    .cmp1_target_i        (cmp1_target_i),
    .inst0_wb_valid_o     (inst0_wb_valid_o),
    .inst0_wb_rd_o        (inst0_wb_rd_o),
    .inst0_wb_value_o     (inst0_wb_value_o),
    .inst1_wb_valid_o     (inst1_wb_valid_o),
    .inst1_wb_rd_o        (inst1_wb_rd_o),
    .inst1_wb_value_o     (inst1_wb_value_o),
    .flush_o              (flush_o),
    .flush_pc_o           (flush_pc_o),
    .endsim_o             (endsim_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cmp0_valid_i && cmp1_valid_i) begin
      assert (cmp0_tag_i != cmp1_tag_i) else begin
        fails++;
        $error("FAIL dup_cmp: observed tag %0d on both ports required distinct", cmp0_tag_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst0_alloc_valid_i  = 1'b0;
    inst1_alloc_valid_i  = 1'b0;
    inst0_alloc_rd_i     = '0;
    inst1_alloc_rd_i     = '0;
    inst0_alloc_rd_wen_i = 1'b0;
    inst1_alloc_rd_wen_i = 1'b0;
    inst0_alloc_endsim_i = 1'b0;
    inst1_alloc_endsim_i = 1'b0;
    cmp0_valid_i = 1'b0; cmp0_tag_i = '0; cmp0_value_i = '0;
    cmp0_redirect_i = 1'b0; cmp0_target_i = '0;
    cmp1_valid_i = 1'b0; cmp1_tag_i = '0; cmp1_value_i = '0;
    cmp1_redirect_i = 1'b0; cmp1_target_i = '0;
  endtask

  task automatic alloc(input logic v1, input logic [4:0] rd0, input logic w0, input logic e0,
                       input logic [4:0] rd1, input logic w1, input logic e1);
    inst0_alloc_valid_i  = 1'b1;
    inst0_alloc_rd_i     = rd0;
    inst0_alloc_rd_wen_i = w0;
    inst0_alloc_endsim_i = e0;
    inst1_alloc_valid_i  = v1;
    inst1_alloc_rd_i     = rd1;
    inst1_alloc_rd_wen_i = w1;
    inst1_alloc_endsim_i = e1;
  endtask

  task automatic cmp(input int port, input logic [TAG_W-1:0] tag, input logic [63:0] val,
                     input logic redir, input logic [63:0] tgt);
    if (port == 0) begin
      cmp0_valid_i = 1'b1; cmp0_tag_i = tag; cmp0_value_i = val;
      cmp0_redirect_i = redir; cmp0_target_i = tgt;
    end else begin
      cmp1_valid_i = 1'b1; cmp1_tag_i = tag; cmp1_value_i = val;
      cmp1_redirect_i = redir; cmp1_target_i = tgt;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_ready",  64'(alloc_ready_o), 64'd1);
    chk("rst_tag0",   64'(inst0_tag_o), 64'd0);
    chk("rst_wb0",    64'(inst0_wb_valid_o), 64'd0);
    chk("rst_wb1",    64'(inst1_wb_valid_o), 64'd0);
    chk("rst_flush",  64'(flush_o), 64'd0);
    chk("rst_endsim", 64'(endsim_o), 64'd0);
    #10 rst_n = 1'b1;

    // Out-of-order completion, in-order dual retire
    alloc(1'b1, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0); tick(); idle();
    chk("pair_tail", 64'(inst0_tag_o), 64'd2);
    cmp(0, 3'd1, 64'h22, 1'b0, 64'h0); tick(); idle();
    chk("ooo_hold", 64'(inst0_wb_valid_o), 64'd0);
    cmp(1, 3'd0, 64'h11, 1'b0, 64'h0); tick(); idle();
    chk("lat_hold", 64'(inst0_wb_valid_o), 64'd0);
    tick();
    chk("dual_wb0_v",   64'(inst0_wb_valid_o), 64'd1);
    chk("dual_wb0_rd",  64'(inst0_wb_rd_o), 64'd5);
    chk("dual_wb0_val", inst0_wb_value_o, 64'h11);
    chk("dual_wb1_v",   64'(inst1_wb_valid_o), 64'd1);
    chk("dual_wb1_rd",  64'(inst1_wb_rd_o), 64'd6);
    chk("dual_wb1_val", inst1_wb_value_o, 64'h22);
    tick();
    chk("dual_done", 64'(inst0_wb_valid_o), 64'd0);

    // rd = x0 retires without a write
    alloc(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    cmp(0, 3'd2, 64'h33, 1'b0, 64'h0); tick(); idle();
    tick();
    chk("x0_nowb", 64'(inst0_wb_valid_o), 64'd0);

    // Fill to the ready threshold, with tag wrap 7 -> 0
    alloc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    alloc(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    chk("wrap_tag0", 64'(inst0_tag_o), 64'd7);
    chk("wrap_tag1", 64'(inst1_tag_o), 64'd0);
    alloc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    chk("ready_at6", 64'(alloc_ready_o), 64'd1);
    alloc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    chk("ready_at7", 64'(alloc_ready_o), 64'd0);
    alloc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    chk("blocked_tag", 64'(inst0_tag_o), 64'd2);
    cmp(0, 3'd3, 64'h3, 1'b0, 64'h0);
    cmp(1, 3'd4, 64'h4, 1'b0, 64'h0); tick(); idle();
    chk("ready_lag", 64'(alloc_ready_o), 64'd0);
    tick();
    chk("ready_after_retire", 64'(alloc_ready_o), 64'd1);
    alloc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    cmp(0, 3'd5, 64'h55, 1'b0, 64'h0); tick(); idle();
    tick();
    chk("pre_rst_wb0_v",   64'(inst0_wb_valid_o), 64'd1);
    chk("pre_rst_wb0_rd",  64'(inst0_wb_rd_o), 64'd7);
    chk("pre_rst_wb0_val", inst0_wb_value_o, 64'h55);

    // Reset with five entries pending
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wb0_v",   64'(inst0_wb_valid_o), 64'd0);
    chk("mid_rst_wb0_val", inst0_wb_value_o, 64'h0);
    chk("mid_rst_ready",   64'(alloc_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tag0", 64'(inst0_tag_o), 64'd0);

    // Redirect on head with younger entries already done
    alloc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    cmp(0, 3'd0, 64'h0, 1'b0, 64'h0);
    cmp(1, 3'd1, 64'h0, 1'b0, 64'h0); tick(); idle();
    tick();
    chk("rd_setup_tag", 64'(inst0_tag_o), 64'd2);
    alloc(1'b1, 5'd8, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0); tick(); idle();
    alloc(1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    cmp(0, 3'd3, 64'h3, 1'b0, 64'h0);
    cmp(1, 3'd4, 64'h4, 1'b0, 64'h0); tick(); idle();
    cmp(0, 3'd2, 64'h2, 1'b1, 64'h8000_0040); tick(); idle();
    chk("redir_noflush_yet", 64'(flush_o), 64'd0);
    tick();
    chk("redir_wb0_v",   64'(inst0_wb_valid_o), 64'd1);
    chk("redir_wb0_rd",  64'(inst0_wb_rd_o), 64'd8);
    chk("redir_wb0_val", inst0_wb_value_o, 64'h2);
    chk("redir_wb1_v",   64'(inst1_wb_valid_o), 64'd0);
    chk("redir_flush",   64'(flush_o), 64'd1);
    chk("redir_pc",      flush_pc_o, 64'h8000_0040);
    tick();
    chk("redir_pulse",  64'(flush_o), 64'd0);
    chk("redir_tail",   64'(inst0_tag_o), 64'd3);
    chk("redir_ready",  64'(alloc_ready_o), 64'd1);
    chk("redir_squash", 64'(inst0_wb_valid_o), 64'd0);

    // Redirect retiring while a new pair allocates
    alloc(1'b0, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); tick(); idle();
    cmp(0, 3'd3, 64'h5, 1'b1, 64'h100); tick(); idle();
    alloc(1'b1, 5'd12, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0); tick(); idle();
    chk("race_wb0_rd", 64'(inst0_wb_rd_o), 64'd11);
    chk("race_flush",  64'(flush_o), 64'd1);
    chk("race_pc",     flush_pc_o, 64'h100);
    chk("race_tail",   64'(inst0_tag_o), 64'd4);
    cmp(0, 3'd4, 64'h99, 1'b0, 64'h0); tick(); idle();
    tick();
    chk("race_dropped", 64'(inst0_wb_valid_o), 64'd0);

    // endsim stops commit and is sticky
    alloc(1'b1, 5'd14, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0); tick(); idle();
    cmp(0, 3'd4, 64'hE, 1'b0, 64'h0);
    cmp(1, 3'd5, 64'hF, 1'b0, 64'h0); tick(); idle();
    tick();
    chk("endsim_wb0_v",  64'(inst0_wb_valid_o), 64'd1);
    chk("endsim_wb0_rd", 64'(inst0_wb_rd_o), 64'd14);
    chk("endsim_wb1_v",  64'(inst1_wb_valid_o), 64'd0);
    chk("endsim_set",    64'(endsim_o), 64'd1);
    tick();
    chk("endsim_stop",   64'(inst0_wb_valid_o), 64'd0);
    chk("endsim_sticky", 64'(endsim_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
